// File: rtl/arp_lookup_pkg.sv
// Shared types for the ARP lookup responder: FSM states, entry layout, widths and log2.
// Used at elaboration time only; no latency and no flow control of its own.
package arp_lookup_pkg;

  localparam int MAC_WIDTH = 48;
  localparam int IP_WIDTH  = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } arp_state_e;

  typedef struct packed {
    logic [IP_WIDTH-1:0]  ip;
    logic [MAC_WIDTH-1:0] mac;
  } arp_entry_t;

  // Ceiling log2, with a floor of 1 so that a depth-1 table still gets an address bit.
  function automatic int log2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/arp_table.sv
// ARP table storage: one write port, one registered read port, one combinational search port.
// Write lands on the next edge; the read result is valid one cycle after rd_en; no backpressure.
module arp_table
  import arp_lookup_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  arp_entry_t    wr_entry,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output arp_entry_t    rd_entry,
  input  logic [AW-1:0] srch_idx,
  output arp_entry_t    srch_entry
);

  arp_entry_t entries_q [DEPTH];
  arp_entry_t entries_d [DEPTH];
  arp_entry_t rd_entry_q;
  arp_entry_t rd_entry_d;

  always_comb begin
    entries_d  = entries_q;
    rd_entry_d = rd_entry_q;
    if (wr_en) entries_d[wr_addr] = wr_entry;
    if (rd_en) rd_entry_d = entries_q[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      rd_entry_q <= '0;
    end else begin
      entries_q  <= entries_d;
      rd_entry_q <= rd_entry_d;
    end
  end

  assign rd_entry   = rd_entry_q;
  assign srch_entry = entries_q[srch_idx];

endmodule

// File: rtl/arp_lookup_sm.sv
// Resolves an LPM next-hop IP to a MAC by linear ARP table search; done k+2 cycles after lpm_vld for a hit at k.
// Upstream waits for arp_done; register req/ack is only serviced when idle. ARP_STATS_EN adds hit/miss counters.
module arp_lookup_sm
  import arp_lookup_pkg::*;
#(
  parameter int NUM_QUEUES     = 8,
  parameter int ARP_LUT_DEPTH  = 32,
  parameter int ARP_DEPTH_BITS = log2(ARP_LUT_DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [IP_WIDTH-1:0]       next_hop_ip,
  input  logic [NUM_QUEUES-1:0]     lpm_output_port,
  input  logic                      lpm_vld,
  input  logic                      lpm_hit,
  output logic                      arp_done,
  output logic                      arp_vld,
  output logic                      arp_hit,
  output logic [MAC_WIDTH-1:0]      next_hop_mac,
  output logic [NUM_QUEUES-1:0]     output_port,
  input  logic [ARP_DEPTH_BITS-1:0] arp_rd_addr,
  input  logic                      arp_rd_req,
  output logic [IP_WIDTH-1:0]       arp_rd_ip,
  output logic [MAC_WIDTH-1:0]      arp_rd_mac,
  output logic                      arp_rd_ack,
  input  logic [ARP_DEPTH_BITS-1:0] arp_wr_addr,
  input  logic                      arp_wr_req,
  input  logic [IP_WIDTH-1:0]       arp_wr_ip,
  input  logic [MAC_WIDTH-1:0]      arp_wr_mac,
  output logic                      arp_wr_ack
`ifdef ARP_STATS_EN
  ,
  output logic [31:0]               arp_hit_count,
  output logic [31:0]               arp_miss_count
`endif
);

  localparam logic [ARP_DEPTH_BITS-1:0] LAST_IDX = ARP_DEPTH_BITS'(ARP_LUT_DEPTH - 1);

  arp_state_e                state_q, state_d;
  logic [IP_WIDTH-1:0]       ip_q, ip_d;
  logic [NUM_QUEUES-1:0]     port_q, port_d;
  logic [ARP_DEPTH_BITS-1:0] idx_q, idx_d;
  logic                      hit_q, hit_d;
  logic [MAC_WIDTH-1:0]      mac_q, mac_d;
  logic [NUM_QUEUES-1:0]     out_port_q, out_port_d;
  logic                      wr_ack_q, wr_ack_d;
  logic                      rd_ack_q, rd_ack_d;
  logic                      tbl_wr_en, tbl_rd_en;
  arp_entry_t                rd_entry, srch_entry;

  arp_table #(
    .DEPTH (ARP_LUT_DEPTH),
    .AW    (ARP_DEPTH_BITS)
  ) u_table (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (tbl_wr_en),
    .wr_addr    (arp_wr_addr),
    .wr_entry   ({arp_wr_ip, arp_wr_mac}),
    .rd_en      (tbl_rd_en),
    .rd_addr    (arp_rd_addr),
    .rd_entry   (rd_entry),
    .srch_idx   (idx_q),
    .srch_entry (srch_entry)
  );

  always_comb begin
    state_d    = state_q;
    ip_d       = ip_q;
    port_d     = port_q;
    idx_d      = idx_q;
    hit_d      = hit_q;
    mac_d      = mac_q;
    out_port_d = out_port_q;
    wr_ack_d   = 1'b0;
    rd_ack_d   = 1'b0;
    tbl_wr_en  = 1'b0;
    tbl_rd_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (lpm_vld) begin
          ip_d   = next_hop_ip;
          port_d = lpm_output_port;
          idx_d  = '0;
          if (lpm_hit) begin
            state_d = ST_SEARCH;
          end else begin
            state_d    = ST_DONE;
            hit_d      = 1'b0;
            mac_d      = '0;
            out_port_d = lpm_output_port;
          end
        // The ack flop masks the still-high level req so one request is served once.
        end else if (arp_wr_req && !wr_ack_q) begin
          tbl_wr_en = 1'b1;
          wr_ack_d  = 1'b1;
        end else if (arp_rd_req && !rd_ack_q) begin
          tbl_rd_en = 1'b1;
          rd_ack_d  = 1'b1;
        end
      end
      ST_SEARCH: begin
        if ((srch_entry.ip != '0) && (srch_entry.ip == ip_q)) begin
          state_d    = ST_DONE;
          hit_d      = 1'b1;
          mac_d      = srch_entry.mac;
          out_port_d = port_q;
        end else if (idx_q == LAST_IDX) begin
          state_d    = ST_DONE;
          hit_d      = 1'b0;
          mac_d      = '0;
          out_port_d = port_q;
        end else begin
          idx_d = idx_q + ARP_DEPTH_BITS'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ip_q       <= '0;
      port_q     <= '0;
      idx_q      <= '0;
      hit_q      <= 1'b0;
      mac_q      <= '0;
      out_port_q <= '0;
      wr_ack_q   <= 1'b0;
      rd_ack_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ip_q       <= ip_d;
      port_q     <= port_d;
      idx_q      <= idx_d;
      hit_q      <= hit_d;
      mac_q      <= mac_d;
      out_port_q <= out_port_d;
      wr_ack_q   <= wr_ack_d;
      rd_ack_q   <= rd_ack_d;
    end
  end

  assign arp_done     = (state_q == ST_DONE);
  assign arp_vld      = (state_q == ST_DONE);
  assign arp_hit      = hit_q;
  assign next_hop_mac = mac_q;
  assign output_port  = out_port_q;
  assign arp_wr_ack   = wr_ack_q;
  assign arp_rd_ack   = rd_ack_q;
  assign arp_rd_ip    = rd_entry.ip;
  assign arp_rd_mac   = rd_entry.mac;

`ifdef ARP_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (state_q == ST_DONE) begin
      if (hit_q) hit_count_d  = hit_count_q + 32'd1;
      else       miss_count_d = miss_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign arp_hit_count  = hit_count_q;
  assign arp_miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_arp_lookup_sm.sv
// Bench for arp_lookup_sm: directed scenarios plus randomized lookups against an array model of the table.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_arp_lookup_sm;

  localparam int NQ    = 8;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   next_hop_ip;
  logic [NQ-1:0] lpm_output_port;
  logic          lpm_vld;
  logic          lpm_hit;
  logic          arp_done;
  logic          arp_vld;
  logic          arp_hit;
  logic [47:0]   next_hop_mac;
  logic [NQ-1:0] output_port;
  logic [AW-1:0] arp_rd_addr;
  logic          arp_rd_req;
  logic [31:0]   arp_rd_ip;
  logic [47:0]   arp_rd_mac;
  logic          arp_rd_ack;
  logic [AW-1:0] arp_wr_addr;
  logic          arp_wr_req;
  logic [31:0]   arp_wr_ip;
  logic [47:0]   arp_wr_mac;
  logic          arp_wr_ack;
`ifdef ARP_STATS_EN
  logic [31:0]   arp_hit_count;
  logic [31:0]   arp_miss_count;
`endif

  int tests  = 0;
  int failed = 0;

  logic [31:0] m_ip  [DEPTH];
  logic [47:0] m_mac [DEPTH];

  always #5 clk = ~clk;

  arp_lookup_sm #(
    .NUM_QUEUES    (NQ),
    .ARP_LUT_DEPTH (DEPTH),
    .ARP_DEPTH_BITS(AW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .next_hop_ip     (next_hop_ip),
    .lpm_output_port (lpm_output_port),
    .lpm_vld         (lpm_vld),
    .lpm_hit         (lpm_hit),
    .arp_done        (arp_done),
    .arp_vld         (arp_vld),
    .arp_hit         (arp_hit),
    .next_hop_mac    (next_hop_mac),
    .output_port     (output_port),
    .arp_rd_addr     (arp_rd_addr),
    .arp_rd_req      (arp_rd_req),
    .arp_rd_ip       (arp_rd_ip),
    .arp_rd_mac      (arp_rd_mac),
    .arp_rd_ack      (arp_rd_ack),
    .arp_wr_addr     (arp_wr_addr),
    .arp_wr_req      (arp_wr_req),
    .arp_wr_ip       (arp_wr_ip),
    .arp_wr_mac      (arp_wr_mac),
    .arp_wr_ack      (arp_wr_ack)
`ifdef ARP_STATS_EN
    ,
    .arp_hit_count   (arp_hit_count),
    .arp_miss_count  (arp_miss_count)
`endif
  );

  // Reference: first valid matching entry wins; latency k+2 on hit, DEPTH+1 on full miss, 1 on LPM miss.
  task automatic model_lookup(input logic [31:0] ip, input bit hit, output int lat,
                              output bit e_hit, output logic [47:0] e_mac);
    lat = DEPTH + 1; e_hit = 0; e_mac = '0;
    if (!hit) begin
      lat = 1;
      return;
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (m_ip[k] != 0 && m_ip[k] == ip) begin
        lat = k + 2; e_hit = 1; e_mac = m_mac[k];
        return;
      end
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) begin
      m_ip[i] = '0; m_mac[i] = '0;
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_model();
  endtask

  task automatic reg_write(input logic [AW-1:0] a, input logic [31:0] ip, input logic [47:0] mac,
                           output int wait_cyc);
    @(negedge clk);
    arp_wr_addr = a; arp_wr_ip = ip; arp_wr_mac = mac; arp_wr_req = 1'b1;
    wait_cyc = 0;
    do begin
      @(negedge clk);
      wait_cyc++;
    end while (!arp_wr_ack && wait_cyc < 50);
    arp_wr_req = 1'b0;
    m_ip[a] = ip; m_mac[a] = mac;
  endtask

  task automatic reg_read(input logic [AW-1:0] a, output logic [31:0] ip, output logic [47:0] mac,
                          output int wait_cyc);
    @(negedge clk);
    arp_rd_addr = a; arp_rd_req = 1'b1;
    wait_cyc = 0;
    do begin
      @(negedge clk);
      wait_cyc++;
    end while (!arp_rd_ack && wait_cyc < 50);
    ip = arp_rd_ip; mac = arp_rd_mac;
    arp_rd_req = 1'b0;
  endtask

  task automatic run_lookup(input logic [31:0] ip, input logic [NQ-1:0] port, input bit hit,
                            output int lat, output bit o_hit, output logic [47:0] o_mac,
                            output logic [NQ-1:0] o_port, output bit o_vld, output bit one_pulse);
    @(negedge clk);
    next_hop_ip = ip; lpm_output_port = port; lpm_hit = hit; lpm_vld = 1'b1;
    @(negedge clk);
    lpm_vld = 1'b0; next_hop_ip = $urandom; lpm_output_port = NQ'($urandom);
    lat = 1;
    while (!arp_done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    o_hit = arp_hit; o_mac = next_hop_mac; o_port = output_port; o_vld = arp_vld;
    @(negedge clk);
    one_pulse = !arp_done && !arp_vld;
  endtask

  task automatic test_reset();
    logic [31:0] rip; logic [47:0] rmac; int w;
    reset_dut();
    tests++; if (arp_done !== 1'b0) begin failed++; $display("FAIL reset_done got=%b exp=0", arp_done); end
    tests++; if (arp_vld !== 1'b0) begin failed++; $display("FAIL reset_vld got=%b exp=0", arp_vld); end
    tests++; if (arp_hit !== 1'b0) begin failed++; $display("FAIL reset_hit got=%b exp=0", arp_hit); end
    tests++; if (next_hop_mac !== 48'h0) begin failed++; $display("FAIL reset_mac got=%h exp=0", next_hop_mac); end
    tests++; if (output_port !== '0) begin failed++; $display("FAIL reset_port got=%h exp=0", output_port); end
    tests++; if (arp_wr_ack !== 1'b0 || arp_rd_ack !== 1'b0) begin
      failed++; $display("FAIL reset_acks got wr=%b rd=%b exp=0,0", arp_wr_ack, arp_rd_ack);
    end
    reg_read(5'd17, rip, rmac, w);
    tests++; if (rip !== 32'h0 || rmac !== 48'h0) begin
      failed++; $display("FAIL reset_entry got ip=%h mac=%h exp=0,0", rip, rmac);
    end
    tests++; if (w !== 1) begin failed++; $display("FAIL reset_rd_ack_lat got=%0d exp=1", w); end
  endtask

  task automatic test_empty_miss();
    int lat; bit h, v, p; logic [47:0] mac; logic [NQ-1:0] port;
    run_lookup(32'h0A000001, 8'h10, 1'b1, lat, h, mac, port, v, p);
    tests++; if (lat !== DEPTH + 1) begin failed++; $display("FAIL empty_lat got=%0d exp=%0d", lat, DEPTH + 1); end
    tests++; if (h !== 1'b0 || mac !== 48'h0) begin failed++; $display("FAIL empty_result got hit=%b mac=%h exp=0,0", h, mac); end
    tests++; if (v !== 1'b1 || p !== 1'b1) begin failed++; $display("FAIL empty_pulse got vld=%b single=%b exp=1,1", v, p); end
  endtask

  task automatic test_hit_idx5();
    int lat, w; bit h, v, p; logic [47:0] mac; logic [NQ-1:0] port; logic [31:0] rip; logic [47:0] rmac;
    reg_write(5'd5, 32'h0A000001, 48'h001122334455, w);
    tests++; if (w !== 1) begin failed++; $display("FAIL wr_ack_lat got=%0d exp=1", w); end
    run_lookup(32'h0A000001, 8'h04, 1'b1, lat, h, mac, port, v, p);
    tests++; if (lat !== 7) begin failed++; $display("FAIL idx5_lat got=%0d exp=7", lat); end
    tests++; if (h !== 1'b1) begin failed++; $display("FAIL idx5_hit got=%b exp=1", h); end
    tests++; if (mac !== 48'h001122334455) begin failed++; $display("FAIL idx5_mac got=%h exp=001122334455", mac); end
    tests++; if (port !== 8'h04) begin failed++; $display("FAIL idx5_port got=%h exp=04", port); end
    tests++; if (p !== 1'b1) begin failed++; $display("FAIL idx5_single_pulse got=%b exp=1", p); end
    tests++; if (arp_hit !== 1'b1 || next_hop_mac !== 48'h001122334455) begin
      failed++; $display("FAIL idx5_hold got hit=%b mac=%h exp=1,001122334455", arp_hit, next_hop_mac);
    end
    reg_read(5'd5, rip, rmac, w);
    tests++; if (rip !== 32'h0A000001 || rmac !== 48'h001122334455) begin
      failed++; $display("FAIL idx5_readback got ip=%h mac=%h", rip, rmac);
    end
  endtask

  task automatic test_lowest_index();
    int lat, w; bit h, v, p; logic [47:0] mac; logic [NQ-1:0] port;
    reg_write(5'd9, 32'hC0A80101, 48'h99AABBCCDD09, w);
    reg_write(5'd2, 32'hC0A80101, 48'h22AABBCCDD02, w);
    run_lookup(32'hC0A80101, 8'h81, 1'b1, lat, h, mac, port, v, p);
    tests++; if (lat !== 4) begin failed++; $display("FAIL lowest_lat got=%0d exp=4", lat); end
    tests++; if (h !== 1'b1 || mac !== 48'h22AABBCCDD02) begin
      failed++; $display("FAIL lowest_mac got hit=%b mac=%h exp=1,22aabbccdd02", h, mac);
    end
    reg_write(5'd2, 32'h0, 48'h0, w);
    run_lookup(32'hC0A80101, 8'h81, 1'b1, lat, h, mac, port, v, p);
    tests++; if (lat !== 11 || mac !== 48'h99AABBCCDD09) begin
      failed++; $display("FAIL invalidate got lat=%0d mac=%h exp=11,99aabbccdd09", lat, mac);
    end
  endtask

  task automatic test_lpm_miss();
    int lat; bit h, v, p; logic [47:0] mac; logic [NQ-1:0] port;
    run_lookup(32'h0A000001, 8'h20, 1'b0, lat, h, mac, port, v, p);
    tests++; if (lat !== 1) begin failed++; $display("FAIL lpm_miss_lat got=%0d exp=1", lat); end
    tests++; if (h !== 1'b0 || mac !== 48'h0 || port !== 8'h20) begin
      failed++; $display("FAIL lpm_miss_result got hit=%b mac=%h port=%h exp=0,0,20", h, mac, port);
    end
    tests++; if (v !== 1'b1 || p !== 1'b1) begin failed++; $display("FAIL lpm_miss_pulse got vld=%b single=%b exp=1,1", v, p); end
  endtask

  task automatic test_wr_mid_search();
    int cyc, done_c, ack_c, w, e_lat; bit e_hit; logic [47:0] e_mac; logic [31:0] rip; logic [47:0] rmac;
    model_lookup(32'h0B0B0B0B, 1'b1, e_lat, e_hit, e_mac);
    @(negedge clk);
    next_hop_ip = 32'h0B0B0B0B; lpm_output_port = 8'h02; lpm_hit = 1'b1; lpm_vld = 1'b1;
    @(negedge clk);
    lpm_vld = 1'b0;
    arp_wr_addr = 5'd7; arp_wr_ip = 32'h0C0C0C0C; arp_wr_mac = 48'hDEADBEEF0007; arp_wr_req = 1'b1;
    cyc = 1; done_c = 0; ack_c = 0;
    while (cyc < 80) begin
      if (arp_done) done_c = cyc;
      if (arp_wr_ack) begin
        ack_c = cyc;
        arp_wr_req = 1'b0;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    arp_wr_req = 1'b0;
    m_ip[7] = 32'h0C0C0C0C; m_mac[7] = 48'hDEADBEEF0007;
    tests++; if (done_c !== e_lat) begin failed++; $display("FAIL mid_wr_done got=%0d exp=%0d", done_c, e_lat); end
    tests++; if (ack_c !== e_lat + 2) begin failed++; $display("FAIL mid_wr_ack got=%0d exp=%0d", ack_c, e_lat + 2); end
    reg_read(5'd7, rip, rmac, w);
    tests++; if (rip !== 32'h0C0C0C0C || rmac !== 48'hDEADBEEF0007) begin
      failed++; $display("FAIL mid_wr_readback got ip=%h mac=%h", rip, rmac);
    end
  endtask

  task automatic test_both_pending();
    int cyc, wr_c, rd_c; logic [31:0] rip; logic [47:0] rmac;
    @(negedge clk);
    arp_wr_addr = 5'd12; arp_wr_ip = 32'h01020304; arp_wr_mac = 48'h0A0B0C0D0E0F; arp_wr_req = 1'b1;
    arp_rd_addr = 5'd12; arp_rd_req = 1'b1;
    cyc = 0; wr_c = 0; rd_c = 0; rip = '0; rmac = '0;
    while (cyc < 20 && rd_c == 0) begin
      @(negedge clk);
      cyc++;
      if (arp_wr_ack) begin wr_c = cyc; arp_wr_req = 1'b0; end
      if (arp_rd_ack) begin rd_c = cyc; rip = arp_rd_ip; rmac = arp_rd_mac; arp_rd_req = 1'b0; end
    end
    arp_wr_req = 1'b0; arp_rd_req = 1'b0;
    m_ip[12] = 32'h01020304; m_mac[12] = 48'h0A0B0C0D0E0F;
    tests++; if (wr_c !== 1 || rd_c !== 2) begin failed++; $display("FAIL both_order got wr=%0d rd=%0d exp=1,2", wr_c, rd_c); end
    tests++; if (rip !== 32'h01020304 || rmac !== 48'h0A0B0C0D0E0F) begin
      failed++; $display("FAIL both_data got ip=%h mac=%h", rip, rmac);
    end
  endtask

  task automatic test_random();
    logic [31:0] pool [6];
    int lat, e_lat, w; bit h, v, p, e_hit, hit; logic [47:0] mac, e_mac; logic [NQ-1:0] port, inport;
    logic [31:0] ip;
    for (int i = 0; i < 6; i++) pool[i] = 32'h0A010100 + 32'(i);
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        ip = ($urandom_range(0, 4) == 0) ? 32'h0 : pool[$urandom_range(0, 5)];
        reg_write(AW'($urandom_range(0, DEPTH - 1)), ip, {$urandom, 16'($urandom)}, w);
      end
      ip = pool[$urandom_range(0, 5)];
      hit = ($urandom_range(0, 3) != 0);
      inport = NQ'($urandom);
      model_lookup(ip, hit, e_lat, e_hit, e_mac);
      run_lookup(ip, inport, hit, lat, h, mac, port, v, p);
      tests++;
      if (lat !== e_lat || h !== e_hit || mac !== e_mac || port !== inport || p !== 1'b1) begin
        failed++;
        $display("FAIL rand_lookup it=%0d got lat=%0d hit=%b mac=%h port=%h single=%b exp lat=%0d hit=%b mac=%h port=%h",
                 it, lat, h, mac, port, p, e_lat, e_hit, e_mac, inport);
      end
    end
  endtask

  task automatic test_reset_mid_search();
    int seen, lat; bit h, v, p; logic [47:0] mac; logic [NQ-1:0] port;
    @(negedge clk);
    next_hop_ip = 32'h0D0D0D0D; lpm_output_port = 8'h01; lpm_hit = 1'b1; lpm_vld = 1'b1;
    @(negedge clk);
    lpm_vld = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clear_model();
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (arp_done || arp_vld) seen++;
      @(negedge clk);
    end
    tests++; if (seen !== 0) begin failed++; $display("FAIL rst_mid_no_done got=%0d exp=0", seen); end
    tests++; if (arp_hit !== 1'b0 || output_port !== '0) begin
      failed++; $display("FAIL rst_mid_outputs got hit=%b port=%h exp=0,0", arp_hit, output_port);
    end
    run_lookup(32'h0A000001, 8'h40, 1'b1, lat, h, mac, port, v, p);
    tests++; if (lat !== DEPTH + 1 || h !== 1'b0 || port !== 8'h40) begin
      failed++; $display("FAIL rst_mid_table_cleared got lat=%0d hit=%b port=%h exp=%0d,0,40", lat, h, port, DEPTH + 1);
    end
  endtask

`ifdef ARP_STATS_EN
  task automatic test_stats();
    int lat, w; bit h, v, p; logic [47:0] mac; logic [NQ-1:0] port;
    reset_dut();
    tests++; if (arp_hit_count !== 0 || arp_miss_count !== 0) begin
      failed++; $display("FAIL stats_reset got hit=%0d miss=%0d exp=0,0", arp_hit_count, arp_miss_count);
    end
    reg_write(5'd3, 32'h0A000003, 48'h000000000333, w);
    for (int i = 0; i < 3; i++) run_lookup(32'h0A000003, 8'h01, 1'b1, lat, h, mac, port, v, p);
    run_lookup(32'h0A000003, 8'h01, 1'b0, lat, h, mac, port, v, p);
    run_lookup(32'h0A0000FF, 8'h01, 1'b1, lat, h, mac, port, v, p);
    tests++; if (arp_hit_count !== 32'd3 || arp_miss_count !== 32'd2) begin
      failed++; $display("FAIL stats_count got hit=%0d miss=%0d exp=3,2", arp_hit_count, arp_miss_count);
    end
    reset_dut();
    tests++; if (arp_hit_count !== 0 || arp_miss_count !== 0) begin
      failed++; $display("FAIL stats_clear got hit=%0d miss=%0d exp=0,0", arp_hit_count, arp_miss_count);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    next_hop_ip = '0; lpm_output_port = '0; lpm_vld = 1'b0; lpm_hit = 1'b0;
    arp_rd_addr = '0; arp_rd_req = 1'b0;
    arp_wr_addr = '0; arp_wr_req = 1'b0; arp_wr_ip = '0; arp_wr_mac = '0;
    clear_model();
    test_reset();
    test_empty_miss();
    test_hit_idx5();
    test_lowest_index();
    test_lpm_miss();
    test_wr_mid_search();
    test_both_pending();
    test_random();
    test_reset_mid_search();
`ifdef ARP_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
